// File: rtl/mcoi_motor_io_pkg.sv
// Shared constants, types and helpers for the motor I/O conditioning stage.
// Optional pfail event counters are enabled by MCOI_PFAIL_COUNT_EN.
package mcoi_motor_io_pkg;

  localparam int DEFAULT_NUM_MOTORS = 16;
  localparam int PFAIL_CNT_W        = 8;

  typedef struct packed {
    logic pfail;
    logic sw_b;
    logic sw_a;
  } status_t;

  function automatic int dbnc_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mcoi_debounce.sv
// One-bit synchroniser plus debouncer; latency SYNC_STAGES+DEBOUNCE_CYCLES clk cycles.
// No flow control: the input is sampled every cycle.
module mcoi_debounce
  import mcoi_motor_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic state_o,
  output logic upd_o
);

  localparam int             CW       = dbnc_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], d_i};
    cnt_d   = '0;
    state_d = state_q;
    // Reaching the last count accepts the new level and restarts the counter.
    if (sync_q[SYNC_STAGES-1] != state_q) begin
      if (cnt_q == CNT_LAST) state_d = sync_q[SYNC_STAGES-1];
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      state_q <= RESET_VAL;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign upd_o   = (state_d != state_q);

endmodule

// File: rtl/mcoi_motor_io_cond.sv
// Motor pin conditioning: debounced status, pfail latch, glitch-free step gating; outputs 1 cycle after inputs.
// No flow control; optional per-channel pfail counters under MCOI_PFAIL_COUNT_EN.
module mcoi_motor_io_cond
  import mcoi_motor_io_pkg::*;
#(
  parameter int NUM_MOTORS      = DEFAULT_NUM_MOTORS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MOTORS-1:0]             pl_pfail,
  input  logic [NUM_MOTORS-1:0]             pl_sw_outa,
  input  logic [NUM_MOTORS-1:0]             pl_sw_outb,
  input  logic [NUM_MOTORS-1:0]             step_clk_i,
  input  logic [NUM_MOTORS-1:0]             step_dir_i,
  input  logic [NUM_MOTORS-1:0]             step_en_i,
  input  logic [NUM_MOTORS-1:0]             step_boost_i,
  input  logic [NUM_MOTORS-1:0]             pfail_clear_i,
  output logic [NUM_MOTORS-1:0]             pl_clk,
  output logic [NUM_MOTORS-1:0]             pl_dir,
  output logic [NUM_MOTORS-1:0]             pl_en,
  output logic [NUM_MOTORS-1:0]             pl_boost,
  output logic [NUM_MOTORS-1:0]             sw_a_o,
  output logic [NUM_MOTORS-1:0]             sw_b_o,
  output logic [NUM_MOTORS-1:0]             pfail_o,
  output logic [NUM_MOTORS-1:0]             pfail_latched_o,
  output logic [NUM_MOTORS-1:0]             blocked_o,
  output logic                              change_o,
  output logic [3*NUM_MOTORS-1:0]           change_mask_o,
  output logic [PFAIL_CNT_W*NUM_MOTORS-1:0] pfail_cnt_o
);

  logic [NUM_MOTORS-1:0] sw_a_db, sw_b_db, pfail_db;
  logic [NUM_MOTORS-1:0] upd_a, upd_b, upd_p;

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
    mcoi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0))
      u_sw_a (.clk(clk), .rst(rst), .d_i(pl_sw_outa[i]), .state_o(sw_a_db[i]), .upd_o(upd_a[i]));
    mcoi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0))
      u_sw_b (.clk(clk), .rst(rst), .d_i(pl_sw_outb[i]), .state_o(sw_b_db[i]), .upd_o(upd_b[i]));
    // pfail powers up asserted so the drivers stay off until the pin proves healthy.
    mcoi_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1))
      u_pfail (.clk(clk), .rst(rst), .d_i(~pl_pfail[i]), .state_o(pfail_db[i]), .upd_o(upd_p[i]));
  end

  logic [NUM_MOTORS-1:0]   latched_q, latched_d, blocked_q, blocked_d;
  logic [NUM_MOTORS-1:0]   clk_in_q, clk_in_d, pass_q, pass_d;
  logic [NUM_MOTORS-1:0]   pl_clk_q, pl_clk_d, pl_dir_q, pl_dir_d;
  logic [NUM_MOTORS-1:0]   pl_en_q, pl_en_d, pl_boost_q, pl_boost_d;
  logic                    change_q, change_d;
  logic [3*NUM_MOTORS-1:0] change_mask_q, change_mask_d;
  status_t                 upd_st;

  always_comb begin
    latched_d  = pfail_db | (latched_q & ~pfail_clear_i);
    // Gating uses the next latch value so a fresh fault blocks in the same cycle.
    blocked_d  = latched_d | (step_dir_i & sw_a_db) | (~step_dir_i & sw_b_db);
    clk_in_d   = step_clk_i;
    // Block is only re-sampled between pulses, so a running pulse is never cut short.
    pass_d     = (clk_in_q & pass_q) | (~clk_in_q & ~blocked_d);
    pl_clk_d   = step_clk_i & pass_d;
    pl_dir_d   = step_dir_i;
    pl_en_d    = step_en_i & ~latched_d;
    pl_boost_d = step_boost_i & pl_en_d;
    upd_st        = '0;
    change_mask_d = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      upd_st = '{pfail: upd_p[i], sw_b: upd_b[i], sw_a: upd_a[i]};
      change_mask_d[i]                = upd_st.sw_a;
      change_mask_d[NUM_MOTORS+i]     = upd_st.sw_b;
      change_mask_d[2*NUM_MOTORS+i]   = upd_st.pfail;
    end
    change_d = |change_mask_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched_q     <= '0;
      blocked_q     <= '0;
      clk_in_q      <= '0;
      pass_q        <= '0;
      pl_clk_q      <= '0;
      pl_dir_q      <= '0;
      pl_en_q       <= '0;
      pl_boost_q    <= '0;
      change_q      <= 1'b0;
      change_mask_q <= '0;
    end else begin
      latched_q     <= latched_d;
      blocked_q     <= blocked_d;
      clk_in_q      <= clk_in_d;
      pass_q        <= pass_d;
      pl_clk_q      <= pl_clk_d;
      pl_dir_q      <= pl_dir_d;
      pl_en_q       <= pl_en_d;
      pl_boost_q    <= pl_boost_d;
      change_q      <= change_d;
      change_mask_q <= change_mask_d;
    end
  end

  assign pl_clk          = pl_clk_q;
  assign pl_dir          = pl_dir_q;
  assign pl_en           = pl_en_q;
  assign pl_boost        = pl_boost_q;
  assign sw_a_o          = sw_a_db;
  assign sw_b_o          = sw_b_db;
  assign pfail_o         = pfail_db;
  assign pfail_latched_o = latched_q;
  assign blocked_o       = blocked_q;
  assign change_o        = change_q;
  assign change_mask_o   = change_mask_q;

`ifdef MCOI_PFAIL_COUNT_EN
  logic [NUM_MOTORS-1:0][PFAIL_CNT_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (upd_p[i] && !pfail_db[i] && (pcnt_q[i] != '1)) pcnt_d[i] = pcnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

  assign pfail_cnt_o = pcnt_q;
`else
  assign pfail_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mcoi_motor_io_cond.sv
// Scoreboard bench for mcoi_motor_io_cond (4 channels, 2 sync stages, debounce 8).
// Honours MCOI_PFAIL_COUNT_EN for the pfail counter expectations.
module tb_mcoi_motor_io_cond;

  localparam int N = 4;

  logic          clk, rst;
  logic [N-1:0]  pl_pfail, pl_sw_outa, pl_sw_outb;
  logic [N-1:0]  step_clk_i, step_dir_i, step_en_i, step_boost_i, pfail_clear_i;
  logic [N-1:0]  pl_clk, pl_dir, pl_en, pl_boost, sw_a_o, sw_b_o, pfail_o, pfail_latched_o, blocked_o;
  logic          change_o;
  logic [3*N-1:0] change_mask_o;
  logic [8*N-1:0] pfail_cnt_o;

  mcoi_motor_io_cond #(.NUM_MOTORS(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .pl_pfail(pl_pfail), .pl_sw_outa(pl_sw_outa), .pl_sw_outb(pl_sw_outb),
    .step_clk_i(step_clk_i), .step_dir_i(step_dir_i), .step_en_i(step_en_i),
    .step_boost_i(step_boost_i), .pfail_clear_i(pfail_clear_i),
    .pl_clk(pl_clk), .pl_dir(pl_dir), .pl_en(pl_en), .pl_boost(pl_boost),
    .sw_a_o(sw_a_o), .sw_b_o(sw_b_o), .pfail_o(pfail_o), .pfail_latched_o(pfail_latched_o),
    .blocked_o(blocked_o), .change_o(change_o), .change_mask_o(change_mask_o),
    .pfail_cnt_o(pfail_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_PFAIL = 0, S_LATCH = 1, S_EN = 2, S_CLK = 3, S_BLK = 4, S_SWA = 5;
  localparam int S_CHG = 6, S_MASK = 7, S_CNT = 8, S_BOOST = 9, S_DIR = 10;

`ifdef MCOI_PFAIL_COUNT_EN
  localparam int          N_EV      = 300;
  localparam logic [31:0] CNT_BASE  = 32'h0100_0000;
  localparam logic [31:0] CNT_FIRST = 32'h0100_0001;
  localparam logic [31:0] CNT_FINAL = 32'h0100_00FF;
`else
  localparam int          N_EV      = 3;
  localparam logic [31:0] CNT_BASE  = 32'h0;
  localparam logic [31:0] CNT_FIRST = 32'h0;
  localparam logic [31:0] CNT_FINAL = 32'h0;
`endif

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      S_PFAIL: return 32'(pfail_o);
      S_LATCH: return 32'(pfail_latched_o);
      S_EN:    return 32'(pl_en);
      S_CLK:   return 32'(pl_clk);
      S_BLK:   return 32'(blocked_o);
      S_SWA:   return 32'(sw_a_o);
      S_CHG:   return 32'(change_o);
      S_MASK:  return 32'(change_mask_o);
      S_CNT:   return 32'(pfail_cnt_o);
      S_BOOST: return 32'(pl_boost);
      S_DIR:   return 32'(pl_dir);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_PFAIL: return "pfail_o";
      S_LATCH: return "pfail_latched_o";
      S_EN:    return "pl_en";
      S_CLK:   return "pl_clk";
      S_BLK:   return "blocked_o";
      S_SWA:   return "sw_a_o";
      S_CHG:   return "change_o";
      S_MASK:  return "change_mask_o";
      S_CNT:   return "pfail_cnt_o";
      S_BOOST: return "pl_boost";
      S_DIR:   return "pl_dir";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dly;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_val(sel_name(sb[i].sel), sig(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    rst = 1'b1;
    pl_pfail = '1; pl_sw_outa = '0; pl_sw_outb = '0;
    step_clk_i = '0; step_dir_i = '0; step_en_i = '1; step_boost_i = 4'h5; pfail_clear_i = '0;
    step(3);
    check_val("rst_pfail_o", 32'(pfail_o), 32'hF);
    check_val("rst_latched", 32'(pfail_latched_o), 32'h0);
    check_val("rst_pl_en", 32'(pl_en), 32'h0);
    check_val("rst_pl_clk", 32'(pl_clk), 32'h0);
    check_val("rst_change", 32'(change_o), 32'h0);

    // Reset release with healthy pfail pins, then clear the power-up latch.
    rst = 1'b0;
    expect_at(1, S_LATCH, 32'hF);
    expect_at(1, S_EN, 32'h0);
    expect_at(1, S_BLK, 32'hF);
    expect_at(9, S_PFAIL, 32'hF);
    expect_at(10, S_PFAIL, 32'h0);
    expect_at(10, S_CHG, 32'h1);
    expect_at(10, S_MASK, 32'hF00);
    expect_at(11, S_CHG, 32'h0);
    expect_at(12, S_LATCH, 32'hF);
    expect_at(12, S_EN, 32'h0);
    step(12);
    pfail_clear_i = '1;
    expect_at(1, S_LATCH, 32'h0);
    expect_at(1, S_EN, 32'hF);
    expect_at(1, S_BOOST, 32'h5);
    expect_at(1, S_BLK, 32'h0);
    step(1);
    pfail_clear_i = '0;

    // Ch0 switch A glitches shorter than the debounce window, then a solid hold.
    for (int g = 0; g < 3; g++) begin
      pl_sw_outa[0] = 1'b1;
      repeat (5) begin expect_at(1, S_SWA, 32'h0); expect_at(1, S_CHG, 32'h0); step(1); end
      pl_sw_outa[0] = 1'b0;
      repeat (5) begin expect_at(1, S_SWA, 32'h0); expect_at(1, S_CHG, 32'h0); step(1); end
    end
    pl_sw_outa[0] = 1'b1;
    expect_at(9, S_SWA, 32'h0);
    expect_at(10, S_SWA, 32'h1);
    expect_at(10, S_CHG, 32'h1);
    expect_at(10, S_MASK, 32'h001);
    expect_at(11, S_CHG, 32'h0);
    step(11);

    // Ch1 driving into engaged switch A: pulses suppressed until direction reverses.
    step_dir_i[1] = 1'b1;
    pl_sw_outa[1] = 1'b1;
    expect_at(1, S_DIR, 32'h2);
    expect_at(10, S_SWA, 32'h3);
    expect_at(10, S_MASK, 32'h002);
    expect_at(11, S_BLK, 32'h2);
    step(11);
    for (int p = 0; p < 2; p++) begin
      step_clk_i[1] = 1'b1;
      repeat (4) begin expect_at(1, S_CLK, 32'h0); expect_at(1, S_BLK, 32'h2); step(1); end
      step_clk_i[1] = 1'b0;
      repeat (4) begin expect_at(1, S_CLK, 32'h0); step(1); end
    end
    step_dir_i[1] = 1'b0;
    expect_at(1, S_BLK, 32'h0);
    expect_at(1, S_DIR, 32'h0);
    step(1);
    step_clk_i[1] = 1'b1;
    repeat (4) begin expect_at(1, S_CLK, 32'h2); step(1); end
    step_clk_i[1] = 1'b0;
    expect_at(1, S_CLK, 32'h0);
    step(2);

    // Ch2 switch engages mid-pulse: the pulse runs full width, the next one is dropped.
    step_dir_i[2] = 1'b1;
    pl_sw_outa[2] = 1'b1;
    expect_at(10, S_MASK, 32'h004);
    expect_at(11, S_BLK, 32'h4);
    step(7);
    step_clk_i[2] = 1'b1;
    repeat (8) begin expect_at(1, S_CLK, 32'h4); step(1); end
    step_clk_i[2] = 1'b0;
    expect_at(1, S_CLK, 32'h0);
    step(4);
    step_clk_i[2] = 1'b1;
    repeat (4) begin expect_at(1, S_CLK, 32'h0); step(1); end
    step_clk_i[2] = 1'b0;
    step(2);

    // Ch3 pfail event with a clear coinciding with the debounced rise.
    pl_pfail[3] = 1'b0;
    expect_at(9, S_PFAIL, 32'h0);
    expect_at(10, S_PFAIL, 32'h8);
    expect_at(10, S_MASK, 32'h800);
    expect_at(10, S_EN, 32'hF);
    expect_at(11, S_EN, 32'h7);
    expect_at(11, S_LATCH, 32'h8);
    expect_at(11, S_BLK, 32'hC);
    expect_at(12, S_LATCH, 32'h8);
    step(10);
    pfail_clear_i[3] = 1'b1;
    step(1);
    pfail_clear_i[3] = 1'b0;
    step(1);
    pl_pfail[3] = 1'b1;
    expect_at(9, S_PFAIL, 32'h8);
    expect_at(10, S_PFAIL, 32'h0);
    expect_at(12, S_LATCH, 32'h8);
    step(12);
    pfail_clear_i[3] = 1'b1;
    expect_at(1, S_LATCH, 32'h0);
    expect_at(1, S_EN, 32'hF);
    step(1);
    pfail_clear_i[3] = 1'b0;

    // Repeated pfail events on ch0 for the event counters.
    for (int e = 0; e < N_EV; e++) begin
      pl_pfail[0] = 1'b0;
      expect_at(10, S_PFAIL, 32'h1);
      if (e == 0) begin
        expect_at(9, S_CNT, CNT_BASE);
        expect_at(10, S_CNT, CNT_FIRST);
      end
      step(11);
      pl_pfail[0] = 1'b1;
      step(11);
    end
    expect_at(1, S_CNT, CNT_FINAL);

    for (int t = 0; t < 50 && sb.size() > 0; t++) step(1);
    check_val("sb_drain", 32'(sb.size()), 32'h0);

    // Reset asserted in the middle of a passing pulse.
    step_clk_i[1] = 1'b1;
    step(1);
    check_val("clk_pre_rst", 32'(pl_clk), 32'h2);
    #1 rst = 1'b1;
    #1 check_val("clk_async_rst", 32'(pl_clk), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
